// File: rtl/ocimem_arb_pkg.sv
// Shared types for the OCI monitor-memory access arbiter.
package ocimem_arb_pkg;

   localparam int unsigned OCI_ADDR_W = 8;
   localparam int unsigned OCI_DATA_W = 32;

   // Requester indices; also the encoding of the round-robin `last` bit
   localparam logic REQ_JTAG  = 1'b0;
   localparam logic REQ_LOCAL = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } arb_state_e;

   typedef struct packed {
      logic                  we;
      logic [OCI_ADDR_W-1:0] addr;
      logic [OCI_DATA_W-1:0] wdata;
   } ocimem_cmd_t;

endpackage

// File: rtl/ocimem_rr_pick.sv
// Two-input round-robin selector: on a tie the requester that did not go last wins.
module ocimem_rr_pick
   import ocimem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] pick_c
);

   // One-hot winner; a lone requester always wins
   always_comb begin
      pick_c = req;
      if (req == 2'b11) begin
         pick_c = (last == REQ_LOCAL) ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/nios_ocimem_access_arbiter.sv
// Shares the OCI monitor memory port between the JTAG debug side (r0) and a
// local sysclk master (r1), one word access at a time.
// Optional feature: define OCIMEM_ARB_TIMEOUT_EN to bound the WAIT state and
// force an error response when the monitor never answers.
module nios_ocimem_access_arbiter
   import ocimem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              r0_req,
   input  logic              r0_we,
   input  logic [ADDR_W-1:0] r0_addr,
   input  logic [DATA_W-1:0] r0_wdata,
   output logic              r0_gnt,
   output logic              r0_done,
   output logic [DATA_W-1:0] r0_rdata,
   output logic              r0_err,
   input  logic              r1_req,
   input  logic              r1_we,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic [DATA_W-1:0] r1_wdata,
   output logic              r1_gnt,
   output logic              r1_done,
   output logic [DATA_W-1:0] r1_rdata,
   output logic              r1_err,
   output logic              mon_go,
   output logic              mon_we,
   output logic [ADDR_W-1:0] mon_addr,
   output logic [DATA_W-1:0] mon_wdata,
   input  logic              mon_ready,
   input  logic [DATA_W-1:0] mon_rdata,
   input  logic              mon_error,
   output logic              busy
);

   // The latched command uses the package struct, so widths must agree
   if (TIMEOUT < 2 || ADDR_W != OCI_ADDR_W || DATA_W != OCI_DATA_W) begin : g_bad_cfg
      $error("nios_ocimem_access_arbiter: unsupported parameter set");
   end

   arb_state_e        state_q, state_d;
   ocimem_cmd_t       cmd_q, cmd_c;
   logic [1:0]        pick_c;
   logic              last_q;
   logic              win_q;
   logic              grant_c;
   logic              finish_c;
   logic              tmo_c;
   logic [DATA_W-1:0] resp_rdata_c;
   logic              resp_err_c;

   ocimem_rr_pick u_pick (
      .req    ({r1_req, r0_req}),
      .last   (last_q),
      .pick_c (pick_c)
   );

`ifdef OCIMEM_ARB_TIMEOUT_EN
   localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
   logic [TMR_W-1:0] timer_q;

   // Counts unanswered WAIT cycles; cleared while the strobe goes out
   always_ff @(posedge clk) begin
      if (reset) begin
         timer_q <= '0;
      end else if (state_q == ST_ISSUE) begin
         timer_q <= '0;
      end else if (state_q == ST_WAIT) begin
         timer_q <= TMR_W'(timer_q + 1'b1);
      end
   end
`endif

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state, grant/finish strobes and response formatting
   always_comb begin
      state_d  = state_q;
      grant_c  = 1'b0;
      finish_c = 1'b0;
      tmo_c    = 1'b0;
      cmd_c    = pick_c[1] ? '{we: r1_we, addr: OCI_ADDR_W'(r1_addr), wdata: OCI_DATA_W'(r1_wdata)}
                           : '{we: r0_we, addr: OCI_ADDR_W'(r0_addr), wdata: OCI_DATA_W'(r0_wdata)};
      case (state_q)
         ST_IDLE: begin
            if (|pick_c) begin
               grant_c = 1'b1;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT: begin
            if (mon_ready) begin
               finish_c = 1'b1;
               state_d  = ST_RESP;
            end
`ifdef OCIMEM_ARB_TIMEOUT_EN
            // Gives up after TIMEOUT+1 WAIT cycles: done lands TIMEOUT+2 after mon_go
            else if (timer_q == TMR_W'(TIMEOUT)) begin
               finish_c = 1'b1;
               tmo_c    = 1'b1;
               state_d  = ST_RESP;
            end
`endif
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      resp_rdata_c = (tmo_c || cmd_q.we) ? '0 : mon_rdata;
      resp_err_c   = tmo_c | mon_error;
   end

   // Grant is decoded in the IDLE cycle the request is seen; suppressed during reset
   assign r0_gnt = grant_c & pick_c[0] & ~reset;
   assign r1_gnt = grant_c & pick_c[1] & ~reset;

   assign mon_we    = cmd_q.we;
   assign mon_addr  = ADDR_W'(cmd_q.addr);
   assign mon_wdata = DATA_W'(cmd_q.wdata);

   // Command latch, strobes, per-requester response registers and RR history
   always_ff @(posedge clk) begin
      if (reset) begin
         cmd_q    <= '0;
         win_q    <= REQ_JTAG;
         last_q   <= REQ_LOCAL;
         mon_go   <= 1'b0;
         busy     <= 1'b0;
         r0_done  <= 1'b0;
         r1_done  <= 1'b0;
         r0_rdata <= '0;
         r0_err   <= 1'b0;
         r1_rdata <= '0;
         r1_err   <= 1'b0;
      end else begin
         mon_go  <= grant_c;
         busy    <= (state_d != ST_IDLE);
         r0_done <= finish_c & (win_q == REQ_JTAG);
         r1_done <= finish_c & (win_q == REQ_LOCAL);
         if (grant_c) begin
            cmd_q <= cmd_c;
            win_q <= pick_c[1];
         end
         if (finish_c && win_q == REQ_JTAG) begin
            r0_rdata <= resp_rdata_c;
            r0_err   <= resp_err_c;
         end
         if (finish_c && win_q == REQ_LOCAL) begin
            r1_rdata <= resp_rdata_c;
            r1_err   <= resp_err_c;
         end
         if (state_q == ST_RESP) begin
            last_q <= win_q;
         end
      end
   end

endmodule

// File: tb/tb_nios_ocimem_access_arbiter.sv
// Directed bench for nios_ocimem_access_arbiter with a behavioural OCI monitor.
// Honors OCIMEM_ARB_TIMEOUT_EN for the timeout scenario.
module tb_nios_ocimem_access_arbiter;

   localparam int unsigned ADDR_W  = 8;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned TIMEOUT = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic              r0_req, r0_we, r0_gnt, r0_done, r0_err;
   logic [ADDR_W-1:0] r0_addr;
   logic [DATA_W-1:0] r0_wdata, r0_rdata;
   logic              r1_req, r1_we, r1_gnt, r1_done, r1_err;
   logic [ADDR_W-1:0] r1_addr;
   logic [DATA_W-1:0] r1_wdata, r1_rdata;
   logic              mon_go, mon_we, mon_ready, mon_error, busy;
   logic [ADDR_W-1:0] mon_addr;
   logic [DATA_W-1:0] mon_wdata, mon_rdata;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // Monitor model controls
   int          mon_lat   = 3;
   logic        mon_never = 1'b0;
   logic [31:0] mon_val   = 32'h0;
   logic        mon_err_v = 1'b0;
   int          n_go      = 0;

   nios_ocimem_access_arbiter #(
      .ADDR_W (ADDR_W), .DATA_W (DATA_W), .TIMEOUT (TIMEOUT)
   ) dut (
      .clk (clk), .reset (reset),
      .r0_req (r0_req), .r0_we (r0_we), .r0_addr (r0_addr), .r0_wdata (r0_wdata),
      .r0_gnt (r0_gnt), .r0_done (r0_done), .r0_rdata (r0_rdata), .r0_err (r0_err),
      .r1_req (r1_req), .r1_we (r1_we), .r1_addr (r1_addr), .r1_wdata (r1_wdata),
      .r1_gnt (r1_gnt), .r1_done (r1_done), .r1_rdata (r1_rdata), .r1_err (r1_err),
      .mon_go (mon_go), .mon_we (mon_we), .mon_addr (mon_addr), .mon_wdata (mon_wdata),
      .mon_ready (mon_ready), .mon_rdata (mon_rdata), .mon_error (mon_error),
      .busy (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Monitor: answers mon_ready mon_lat cycles after the mon_go cycle
   initial begin
      mon_ready = 1'b0; mon_rdata = '0; mon_error = 1'b0;
      forever begin
         @(negedge clk);
         if (mon_go) begin
            n_go++;
            if (!mon_never) begin
               repeat (mon_lat) @(posedge clk);
               #1 mon_ready = 1'b1; mon_rdata = mon_val; mon_error = mon_err_v;
               @(posedge clk);
               #1 mon_ready = 1'b0; mon_rdata = '0; mon_error = 1'b0;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive_req(input bit idx, input logic on, input logic we,
                            input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd);
      if (!idx) begin
         r0_req = on; r0_we = we; r0_addr = addr; r0_wdata = wd;
      end else begin
         r1_req = on; r1_we = we; r1_addr = addr; r1_wdata = wd;
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // Waits (bounded) for the requester's done pulse; returns its cycle or -1
   task automatic wait_done(input bit idx, input int budget, output int at);
      bit seen = 1'b0;
      at = -1;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (idx ? r1_done : r0_done) begin
            seen = 1'b1;
            at   = cyc;
         end
      end
      if (!seen) check("done_wait_expired", 64'd0, 64'd1);
   endtask

   // One complete access from a single requester with full latency/response checks
   task automatic run_access(input string tag, input bit idx, input logic we,
                             input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd,
                             input logic [DATA_W-1:0] exp_rd, input logic exp_err, input int exp_lat);
      int t0, td;
      @(posedge clk); #1 drive_req(idx, 1'b1, we, addr, wd);
      @(negedge clk); t0 = cyc;
      check({tag, "_gnt"},       idx ? r1_gnt : r0_gnt, 1);
      check({tag, "_gnt_other"}, idx ? r0_gnt : r1_gnt, 0);
      @(posedge clk); #1 drive_req(idx, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
      check({tag, "_go"},  mon_go, 1);
      check({tag, "_cmd"}, {mon_we, mon_addr, mon_wdata}, {we, addr, wd});
      wait_done(idx, 40, td);
      if (td >= 0) begin
         check({tag, "_lat"},        td - t0, exp_lat);
         check({tag, "_rdata"},      idx ? r1_rdata : r0_rdata, exp_rd);
         check({tag, "_err"},        idx ? r1_err : r0_err, exp_err);
         check({tag, "_done_other"}, idx ? r0_done : r1_done, 0);
         check({tag, "_cmd_hold"},   {mon_we, mon_addr, mon_wdata}, {we, addr, wd});
      end
   endtask

   initial begin
      int t0, tg, td, seen, go0;
      bit got;
      reset = 1'b1;
      drive_req(1'b0, 1'b0, 1'b0, '0, '0);
      drive_req(1'b1, 1'b0, 1'b0, '0, '0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_r0", {r0_gnt, r0_done, r0_rdata, r0_err}, 0);
      check("rst_r1", {r1_gnt, r1_done, r1_rdata, r1_err}, 0);
      check("rst_mon", {mon_go, mon_we, mon_addr, mon_wdata, busy}, 0);
      #1 reset = 1'b0;

      // Single read, ready 3 cycles after go
      mon_val = 32'hDEADBEEF; mon_err_v = 1'b0; go0 = n_go;
      run_access("rd0", 1'b0, 1'b0, 8'h10, 32'h0, 32'hDEADBEEF, 1'b0, 5);
      check("rd0_go_count", n_go - go0, 1);

      // Contention from reset: r0 first, then r1, then alternation
      do_reset();
      mon_val = 32'h11112222;
      @(posedge clk); #1 drive_req(1'b0, 1'b1, 1'b0, 8'h01, '0); drive_req(1'b1, 1'b1, 1'b0, 8'h02, '0);
      @(negedge clk); t0 = cyc;
      check("tie1_r0_gnt", r0_gnt, 1);
      check("tie1_r1_gnt", r1_gnt, 0);
      @(posedge clk); #1 r0_req = 1'b0;
      got = 1'b0; tg = -1;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (r1_gnt) begin got = 1'b1; tg = cyc; end
      end
      check("tie1_r1_gnt_lat", tg - t0, 6);
      check("tie1_r0_rdata", r0_rdata, 32'h11112222);
      @(posedge clk); #1 r1_req = 1'b0;
      wait_done(1'b1, 40, td);
      check("tie1_r1_rdata", r1_rdata, 32'h11112222);
      @(posedge clk); #1 r0_req = 1'b1; r1_req = 1'b1;
      @(negedge clk);
      check("tie2_r0_gnt", r0_gnt, 1);
      check("tie2_r1_gnt", r1_gnt, 0);
      @(posedge clk); #1 r0_req = 1'b0; r1_req = 1'b0;
      wait_done(1'b0, 40, td);
      @(posedge clk); #1 r0_req = 1'b1; r1_req = 1'b1;
      @(negedge clk);
      check("tie3_r1_gnt", r1_gnt, 1);
      check("tie3_r0_gnt", r0_gnt, 0);
      @(posedge clk); #1 r0_req = 1'b0; r1_req = 1'b0;
      wait_done(1'b1, 40, td);

      // Write returns zero data even though the monitor drives rdata
      mon_val = 32'h12345678;
      run_access("wr1", 1'b1, 1'b1, 8'h3F, 32'hA5A5A5A5, 32'h0, 1'b0, 5);
      check("wr1_r0_hold", r0_rdata, 32'h11112222);

      // Monitor error with ready
      mon_val = 32'hCAFEF00D; mon_err_v = 1'b1;
      run_access("err0", 1'b0, 1'b0, 8'h20, '0, 32'hCAFEF00D, 1'b1, 5);
      mon_err_v = 1'b0;

      // Monitor never answers
      mon_never = 1'b1;
`ifdef OCIMEM_ARB_TIMEOUT_EN
      run_access("tmo", 1'b0, 1'b0, 8'h30, '0, 32'h0, 1'b1, TIMEOUT + 3);
`else
      @(posedge clk); #1 drive_req(1'b0, 1'b1, 1'b0, 8'h30, '0);
      @(negedge clk); check("notmo_gnt", r0_gnt, 1);
      @(posedge clk); #1 drive_req(1'b0, 1'b0, 1'b0, '0, '0);
      seen = 0;
      repeat (30) begin
         @(negedge clk);
         if (r0_done) seen++;
      end
      check("notmo_busy", busy, 1);
      check("notmo_no_done", seen, 0);
      do_reset();
`endif

      // Reset while in WAIT: abort silently, then recover
      @(posedge clk); #1 drive_req(1'b1, 1'b1, 1'b0, 8'h44, '0);
      @(negedge clk); check("rstw_gnt", r1_gnt, 1);
      @(posedge clk); #1 drive_req(1'b1, 1'b0, 1'b0, '0, '0);
      repeat (3) @(negedge clk);
      check("rstw_busy_before", busy, 1);
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      check("rstw_r0", {r0_gnt, r0_done, r0_rdata, r0_err}, 0);
      check("rstw_r1", {r1_gnt, r1_done, r1_rdata, r1_err}, 0);
      check("rstw_mon", {mon_go, mon_we, mon_addr, mon_wdata, busy}, 0);
      go0 = n_go; seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (r0_done || r1_done) seen++;
      end
      check("rstw_no_done", seen, 0);
      check("rstw_no_go", n_go - go0, 0);
      mon_never = 1'b0; mon_val = 32'h0BADF00D;
      run_access("post_rst", 1'b1, 1'b0, 8'h55, '0, 32'h0BADF00D, 1'b0, 5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
